// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S stream transmitter: framing-mode encodings
// and the legal ranges for the transmitter parameters.
package i2s_pkg;

  typedef enum logic {
    I2S_MODE_PHILIPS = 1'b0,
    I2S_MODE_LJ      = 1'b1
  } i2s_mode_e;

  localparam int SAMPLE_W_MIN   = 8;
  localparam int SAMPLE_W_MAX   = 32;
  localparam int SLOT_W_MAX     = 64;
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 64;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Frame buffer for the I2S transmitter: power-of-two deep FIFO with show-ahead
// read data and an occupancy count; state changes on the falling clock edge.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; the level count alone decides what is valid.
  always_ff @(negedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_stream.sv
// Streaming I2S / left-justified transmitter with a frame FIFO.
// Define I2S_TX_STREAM_REPEAT_EN to resend the previous frame on underflow instead of zeros.
module i2s_tx_stream
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sclk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          mode,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          underflow_clr
);

  localparam int CW = $clog2(SLOT_W);
  localparam logic [CW-1:0] LAST = CW'(SLOT_W - 1);

  if (SAMPLE_W < SAMPLE_W_MIN || SAMPLE_W > SAMPLE_W_MAX) begin : g_bad_sample_w
    $error("i2s_tx_stream: SAMPLE_W out of range");
  end
  if (SLOT_W < SAMPLE_W || SLOT_W > SLOT_W_MAX) begin : g_bad_slot_w
    $error("i2s_tx_stream: SLOT_W out of range");
  end
  if (FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2s_tx_stream: FIFO_DEPTH must be a power of two in range");
  end

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  lr_nxt;
  logic [SAMPLE_W-1:0]   left_reg;
  logic [SAMPLE_W-1:0]   right_reg;
  logic [SAMPLE_W-1:0]   load_left;
  logic [SAMPLE_W-1:0]   load_right;
  logic [SAMPLE_W-1:0]   cur_left;
  logic [SAMPLE_W-1:0]   cur_right;
  logic [SAMPLE_W-1:0]   slot_shift;
  logic [2*SAMPLE_W-1:0] fifo_data;
  logic                  lj_q;
  logic                  lj_next;
  i2s_mode_e             mode_q;
  i2s_mode_e             mode_nxt;
  logic                  frame_start;
  logic                  pop;
  logic                  full;
  logic                  empty;

  i2s_frame_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (rst_n),
    .push    (s_valid),
    .wr_data ({s_left, s_right}),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign s_ready     = !full;
  assign frame_start = en && lrclk && (cnt == LAST);
  assign pop         = frame_start && !empty;

  always_comb begin
    load_left  = fifo_data[2*SAMPLE_W-1:SAMPLE_W];
    load_right = fifo_data[SAMPLE_W-1:0];
    if (!pop) begin
`ifdef I2S_TX_STREAM_REPEAT_EN
      load_left  = left_reg;
      load_right = right_reg;
`else
      load_left  = '0;
      load_right = '0;
`endif
    end
  end

  // The left-justified bit for the next slot position; shifting past the
  // sample width naturally yields the zero padding.
  always_comb begin
    cnt_nxt    = (cnt == LAST) ? '0 : cnt + CW'(1);
    lr_nxt     = (cnt == LAST) ? ~lrclk : lrclk;
    cur_left   = frame_start ? load_left : left_reg;
    cur_right  = frame_start ? load_right : right_reg;
    slot_shift = (lr_nxt ? cur_right : cur_left) << cnt_nxt;
    lj_next    = slot_shift[SAMPLE_W-1];
    mode_nxt   = frame_start ? i2s_mode_e'(mode) : mode_q;
  end

  // Philips framing reuses the left-justified bit from one cycle earlier.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= LAST;
      lrclk     <= 1'b1;
      lj_q      <= 1'b0;
      sdata     <= 1'b0;
      left_reg  <= '0;
      right_reg <= '0;
      mode_q    <= I2S_MODE_PHILIPS;
    end else if (!en) begin
      cnt   <= LAST;
      lrclk <= 1'b1;
      lj_q  <= 1'b0;
      sdata <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      lrclk <= lr_nxt;
      lj_q  <= lj_next;
      sdata <= (mode_nxt == I2S_MODE_LJ) ? lj_next : lj_q;
      if (frame_start) begin
        left_reg  <= load_left;
        right_reg <= load_right;
        mode_q    <= mode_nxt;
      end
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (frame_start && empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: doc/i2s_tx_stream.md
I2S_TX_STREAM -- requirements
Module: i2s_tx_stream

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, audio sample width in bits (8..32).
REQ-002 SHALL have parameter SLOT_W, default 32, sclk cycles per channel slot (SAMPLE_W..64).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, frame buffer depth (power of 2, 2..64).
REQ-004 sclk  input  1  bit clock; all state updates on the falling edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  transmit enable.
REQ-007 mode  input  1  framing mode: 0 = Philips I2S (one-bit delay), 1 = left-justified.
REQ-008 s_valid  input  1  frame offered.
REQ-009 s_ready  output  1  frame accepted when high together with s_valid.
REQ-010 s_left, s_right  input  SAMPLE_W  left and right samples of the offered frame.
REQ-011 lrclk  output  1  word select: 0 = left slot, 1 = right slot.
REQ-012 sdata  output  1  serial data, MSB first.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of buffered frames.
REQ-014 underflow  output  1  sticky underflow flag.
REQ-015 underflow_clr  input  1  clears underflow.

Function
REQ-016 Handshake: s_ready SHALL equal !full, combinationally; a push SHALL occur on every falling edge where s_valid && s_ready.
REQ-017 Frame timing: frame = 2*SLOT_W sclk cycles; slot counter 0..SLOT_W-1; lrclk toggles when the counter wraps.
REQ-018 Frame start: the frame starts when the counter wraps at the end of the right slot.
  - FIFO non-empty: SHALL pop one frame into the shift registers.
  - FIFO empty: SHALL load zeros and set underflow.
REQ-019 Left-justified slot bit k (k < SAMPLE_W) SHALL be sample bit SAMPLE_W-1-k; bits k >= SAMPLE_W SHALL be 0.
REQ-020 I2S mode SHALL output the left-justified stream delayed by one sclk relative to lrclk, so the MSB follows the lrclk edge by one cycle.
REQ-021 Latency: the first frame pushed while idle SHALL have its left MSB on sdata no later than 2*SLOT_W+1 cycles after en rises.
REQ-022 Simultaneous push and pop SHALL leave fifo_level unchanged; a push into an empty FIFO on a pop cycle SHALL NOT bypass (the pop still underflows).
REQ-023 mode SHALL be sampled only at frame start; a mid-frame change takes effect at the next frame.
REQ-024 en low:
  - counter held at SLOT_W-1, lrclk = 1, sdata = 0, no pops.
  - FIFO keeps its contents and s_ready stays functional.
REQ-025 en rising: the next edge SHALL be a frame start, lrclk -> 0.
REQ-026 underflow_clr SHALL clear underflow; a simultaneous underflow event SHALL win (flag stays 1).

Reset
REQ-027 rst_n low SHALL immediately force: lrclk = 1, sdata = 0, fifo_level = 0, s_ready = 1, underflow = 0, counter = SLOT_W-1, shift registers = 0.
REQ-028 Reset mid-frame SHALL discard the FIFO contents and the partial frame; after release, the first frame starts on the first edge with en = 1.

Configuration
REQ-029 Macro I2S_TX_STREAM_REPEAT_EN:
  - Defined: on underflow, the last transmitted frame SHALL be retransmitted.
  - Undefined: zeros SHALL be transmitted.
  - underflow SHALL be set in both cases.

Structure
REQ-030 Package i2s_pkg SHALL hold the mode encodings (I2S_MODE_PHILIPS = 0, I2S_MODE_LJ = 1) and the parameter-range constants.
REQ-031 The FIFO SHALL be the sub-module i2s_frame_fifo (synchronous, width 2*SAMPLE_W, FIFO_DEPTH deep, exposes level); the serializer stays in i2s_tx_stream.

Verification (SAMPLE_W=24, SLOT_W=32, DEPTH=4)
REQ-032 mode=1, push L=0xA5F00F, R=0x123456, en=1 -> left slot bits 0..23 = 0xA5F00F MSB-first, bits 24..31 = 0; right slot carries 0x123456.
REQ-033 Same frame, mode=0 -> sdata is identical but lags lrclk edges by one cycle; the cycle right after the edge carries the previous slot's last bit (0).
REQ-034 Push 5 frames back-to-back with en=0:
  - s_ready drops after the 4th push, fifo_level = 4.
  - en=1 -> pops every 64 cycles, s_ready returns after the first pop.
REQ-035 Empty FIFO at frame start -> zeros transmitted (REPEAT_EN: previous frame) and underflow = 1; underflow_clr pulse -> 0; clr coincident with a new underflow -> stays 1.
REQ-036 Assert rst_n low mid-left-slot with 3 frames queued -> outputs take reset values asynchronously and fifo_level = 0; after release, a new push is transmitted first.
REQ-037 Toggle mode mid-frame -> current frame unchanged; the new framing appears from the next lrclk 1->0 edge.
